// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts n bits of a parallel word out MSB-first
// over valid/ready and tracks the expected overlapping 3-ones detection count.
module seq_pattern_tx #(
   parameter int WIDTH = 16,
   parameter int LEN_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic [LEN_W-1:0] len,
   output logic             ready,
   output logic             x_out,
   output logic             x_valid,
   input  logic             x_ready,
   output logic             done,
   output logic [LEN_W-1:0] exp_hits
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

   state_t           state_r, state_s;
   logic [WIDTH-1:0] shreg_r, shreg_s;
   logic [LEN_W-1:0] cnt_r, cnt_s;
   logic [LEN_W-1:0] hits_r, hits_s;
   logic [1:0]       run_r, run_s;
   logic             x_out_r, x_out_s;
   logic             x_valid_r, x_valid_s;
   logic             done_r, done_s;
   logic             ready_r, ready_s;
   logic [LEN_W-1:0] n_s;
   logic [WIDTH-1:0] aligned_s;
   logic             bit_s;

   // Next-state, datapath and registered-output values
   always_comb begin
      state_s   = state_r;
      shreg_s   = shreg_r;
      cnt_s     = cnt_r;
      hits_s    = hits_r;
      run_s     = run_r;
      x_out_s   = x_out_r;
      x_valid_s = x_valid_r;
      done_s    = 1'b0;
      ready_s   = ready_r;
      n_s       = (len > WIDTH_L) ? WIDTH_L : len;
      // Left-justify the word so the first bit to send sits at the MSB
      aligned_s = data << (WIDTH_L - n_s);
      bit_s     = shreg_r[WIDTH-1];

      case (state_r)
         IDLE: begin
            if (load) begin
               shreg_s = aligned_s;
               run_s   = 2'd0;
               hits_s  = {LEN_W{1'b0}};
               ready_s = 1'b0;
               if (n_s == {LEN_W{1'b0}}) begin
                  state_s = DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s   = SEND;
                  cnt_s     = n_s;
                  x_valid_s = 1'b1;
                  x_out_s   = aligned_s[WIDTH-1];
               end
            end else begin
               state_s = IDLE;
               ready_s = 1'b1;
            end
         end
         SEND: begin
            if (x_ready) begin
               if (bit_s && (run_r == 2'd2)) begin
                  hits_s = hits_r + LEN_W'(1);
               end else begin
                  hits_s = hits_r;
               end
               if (bit_s) begin
                  run_s = (run_r == 2'd2) ? 2'd2 : run_r + 2'd1;
               end else begin
                  run_s = 2'd0;
               end
               shreg_s = shreg_r << 1;
               cnt_s   = cnt_r - LEN_W'(1);
               if (cnt_r == LEN_W'(1)) begin
                  x_valid_s = 1'b0;
                  x_out_s   = 1'b0;
                  state_s   = DONE;
                  done_s    = 1'b1;
               end else begin
                  x_out_s = shreg_r[WIDTH-2];
               end
            end else begin
               state_s = SEND;
            end
         end
         DONE: begin
            state_s = IDLE;
            ready_s = 1'b1;
         end
         default: begin
            state_s   = IDLE;
            ready_s   = 1'b1;
            x_valid_s = 1'b0;
            x_out_s   = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         shreg_r   <= {WIDTH{1'b0}};
         cnt_r     <= {LEN_W{1'b0}};
         hits_r    <= {LEN_W{1'b0}};
         run_r     <= 2'd0;
         x_out_r   <= 1'b0;
         x_valid_r <= 1'b0;
         done_r    <= 1'b0;
         ready_r   <= 1'b1;
      end else begin
         state_r   <= state_s;
         shreg_r   <= shreg_s;
         cnt_r     <= cnt_s;
         hits_r    <= hits_s;
         run_r     <= run_s;
         x_out_r   <= x_out_s;
         x_valid_r <= x_valid_s;
         done_r    <= done_s;
         ready_r   <= ready_s;
      end
   end

   assign ready    = ready_r;
   assign x_out    = x_out_r;
   assign x_valid  = x_valid_r;
   assign done     = done_r;
   assign exp_hits = hits_r;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: expected bits and hit counts are queued
// at load time and consumed by a monitor as the DUT transfers and completes.
module tb_seq_pattern_tx;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] data;
   logic [4:0]  len;
   logic        ready;
   logic        x_out;
   logic        x_valid;
   logic        x_ready;
   logic        done;
   logic [4:0]  exp_hits;

   int checks = 0;
   int errors = 0;

   logic exp_bits[$];
   int   exp_hits_q[$];

   logic stalled = 1'b0;
   logic held    = 1'b0;

   seq_pattern_tx #(.WIDTH(16), .LEN_W(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .data     (data),
      .len      (len),
      .ready    (ready),
      .x_out    (x_out),
      .x_valid  (x_valid),
      .x_ready  (x_ready),
      .done     (done),
      .exp_hits (exp_hits)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Count windows of three consecutive ones in the sent sequence
   function automatic int ref_hits(input logic [15:0] d, input int n);
      int h;
      h = 0;
      for (int i = n - 1; i >= 2; i--) begin
         if (d[i] && d[i-1] && d[i-2]) h++;
      end
      return h;
   endfunction

   function automatic logic pick_ready(input int mode, input int cyc);
      logic [3:0] pat;
      pat = 4'b1001;
      if (mode == 0) return 1'b1;
      else if (mode == 1) return pat[3 - (cyc % 4)];
      else return 1'($urandom_range(0, 1));
   endfunction

   // Monitor: pops one expected bit per transfer, one hit count per done pulse
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled && x_valid) check("stall_stable", x_out, held);
         stalled = x_valid && !x_ready;
         held    = x_out;
         if (x_valid && x_ready) begin
            check("xfer_pending", exp_bits.size() > 0, 1);
            if (exp_bits.size() > 0) check("bit", x_out, exp_bits.pop_front());
         end
         if (done) begin
            check("bits_left_at_done", exp_bits.size(), 0);
            check("hits_pending", exp_hits_q.size() > 0, 1);
            if (exp_hits_q.size() > 0) check("exp_hits", exp_hits, exp_hits_q.pop_front());
         end
      end
   end

   task automatic run_burst(input logic [15:0] d, input int l, input int mode, input int inj);
      int n;
      int h;
      int cyc;
      logic got;
      n = (l > 16) ? 16 : l;
      h = ref_hits(d, n);
      for (int i = n - 1; i >= 0; i--) exp_bits.push_back(d[i]);
      exp_hits_q.push_back(h);
      @(posedge clk); #1;
      check("ready_idle", ready, 1);
      load    = 1'b1;
      data    = d;
      len     = 5'(l);
      x_ready = pick_ready(mode, 0);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         load = (cyc == inj);
         if (load) data = 16'h0000;
         x_ready = pick_ready(mode, cyc);
         if (n == 0) check("no_valid_len0", x_valid, 0);
         if (done) got = 1'b1;
      end
      check("done_seen", got, 1);
      if (mode == 0) check("done_latency", cyc, (n == 0) ? 1 : n + 1);
      load = 1'b0;
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("ready_after", ready, 1);
      check("hits_hold", exp_hits, h);
   endtask

   initial begin
      rst     = 1'b0;
      load    = 1'b0;
      data    = 16'h0000;
      len     = 5'd0;
      x_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_ready", ready, 1);
      check("rst_valid", x_valid, 0);
      check("rst_done", done, 0);
      check("rst_hits", exp_hits, 0);
      check("rst_xout", x_out, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_burst(16'h00F7, 8, 0, 0);
      run_burst(16'h00F7, 8, 1, 0);
      run_burst(16'h1234, 0, 0, 0);
      run_burst(16'hFFFF, 20, 0, 0);
      run_burst(16'h00F7, 8, 0, 2);

      // Reset mid-burst after three transfers
      for (int i = 7; i >= 0; i--) exp_bits.push_back(1'(16'h00F7 >> i));
      exp_hits_q.push_back(3);
      @(posedge clk); #1;
      load    = 1'b1;
      data    = 16'h00F7;
      len     = 5'd8;
      x_ready = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      exp_bits.delete();
      exp_hits_q.delete();
      #1;
      check("midrst_valid", x_valid, 0);
      check("midrst_hits", exp_hits, 0);
      check("midrst_ready", ready, 1);
      @(posedge clk); #1 rst = 1'b0;
      run_burst(16'h0007, 3, 0, 0);

      for (int k = 0; k < 12; k++) begin
         run_burst(16'($urandom), int'($urandom_range(0, 20)), 2, int'($urandom_range(0, 6)));
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
